// File: rtl/fibo_pkg.sv
// Shared definitions for the Fibonacci generator / inverse pair.
// Widths, limits and the FSM state encoding live here.
package fibo_pkg;

    localparam int VAL_W   = 21;
    localparam int IDX_W   = 5;
    localparam int MAX_IDX = 31;
    localparam int FIB_MAX = 1346269;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OP   = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fibo_index.sv
// Inverse Fibonacci: largest i <= 31 with fib(i) <= num, plus exact-hit flag.
// Walks the sequence one term per cycle until the next term exceeds num.
module fibo_index
    import fibo_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [VAL_W-1:0] num,
    output logic [IDX_W-1:0] idx,
    output logic             exact,
    output logic             ready,
    output logic             done_tick
);

    state_t             state_q, state_d;
    logic [VAL_W:0]     t0_q, t0_d;
    logic [VAL_W:0]     t1_q, t1_d;
    logic [VAL_W-1:0]   v_q, v_d;
    logic [IDX_W-1:0]   n_q, n_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               exact_q, exact_d;

    logic [VAL_W:0]     v_ext;
    logic               stop;

    assign v_ext = {1'b0, v_q};
    // Stopping at n==31 keeps t0+t1 from ever reaching fib(33).
    assign stop  = (n_q == IDX_W'(MAX_IDX)) || (t1_q > v_ext);

    always_comb begin
        state_d   = state_q;
        t0_d      = t0_q;
        t1_d      = t1_q;
        v_d       = v_q;
        n_d       = n_q;
        idx_d     = idx_q;
        exact_d   = exact_q;
        ready     = 1'b0;
        done_tick = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    v_d     = num;
                    t0_d    = '0;
                    t1_d    = (VAL_W+1)'(1);
                    n_d     = '0;
                    state_d = S_OP;
                end
            end
            S_OP: begin
                if (stop) begin
                    idx_d   = n_q;
                    exact_d = (t0_q == v_ext);
                    state_d = S_DONE;
                end else begin
                    t0_d = t1_q;
                    t1_d = t0_q + t1_q;
                    n_d  = n_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                done_tick = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t0_q    <= '0;
            t1_q    <= '0;
            v_q     <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            exact_q <= 1'b0;
        end else begin
            state_q <= state_d;
            t0_q    <= t0_d;
            t1_q    <= t1_d;
            v_q     <= v_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            exact_q <= exact_d;
        end
    end

    assign idx   = idx_q;
    assign exact = exact_q;

endmodule
